// File: rtl/raster_pkg.sv
// Shared types and constants for the raster coordinate sequencer.
package raster_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned FRAME_COUNT_W = 8;

endpackage

// File: rtl/wrap_counter.sv
// Counter that steps 0..LIMIT-1 and wraps by explicit compare, so LIMIT == 2^W is safe.
module wrap_counter #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 256
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         at_max
);

  localparam logic [W-1:0] MaxVal = W'(LIMIT - 1);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    at_max = (value_q == MaxVal);
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/raster_scan.sv
// Row-major (x, y) coordinate generator over valid/ready, one frame per start request.
module raster_scan
  import raster_pkg::*;
#(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned HEIGHT  = 11,
  parameter int unsigned X_COUNT = 640,
  parameter int unsigned Y_COUNT = 480
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tock_start,
  input  logic                     tock_abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_x,
  output logic [HEIGHT-1:0]        out_y,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic [FRAME_COUNT_W-1:0] frame_count
);

  state_e state_q, state_d;
  logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;

  logic fire;
  logic cnt_clear;
  logic x_inc, y_inc;
  logic x_at_max, y_at_max;
  logic last_coord;

  // Counters only move on an accepted beat; abort or a fresh start zeroes them.
  assign fire       = out_valid & out_ready;
  assign cnt_clear  = tock_abort | ((state_q == StIdle) & tock_start);
  assign x_inc      = fire;
  assign y_inc      = fire & x_at_max;
  assign last_coord = x_at_max & y_at_max;

  wrap_counter #(
    .W     (WIDTH),
    .LIMIT (X_COUNT)
  ) u_x_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (x_inc),
    .value  (out_x),
    .at_max (x_at_max)
  );

  wrap_counter #(
    .W     (HEIGHT),
    .LIMIT (Y_COUNT)
  ) u_y_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (y_inc),
    .value  (out_y),
    .at_max (y_at_max)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    frame_count_d = frame_count_q;
    unique case (state_q)
      StIdle: begin
        if (tock_start && !tock_abort) begin
          state_d = StScan;
        end
      end
      StScan: begin
        if (tock_abort) begin
          state_d = StIdle;
        end else if (fire && last_coord) begin
          // Count lands on the same edge that raises done.
          state_d       = StDone;
          frame_count_d = frame_count_q + FRAME_COUNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    out_valid   = (state_q == StScan);
    busy        = (state_q == StScan);
    done        = (state_q == StDone);
    out_last    = out_valid & last_coord;
    frame_count = frame_count_q;
  end

endmodule

// File: tb/tb_raster_scan.sv
// Directed bench for raster_scan: frame-level reference model plus literal spot checks.
module tb_raster_scan;

  localparam int unsigned XC = 3;
  localparam int unsigned YC = 2;
  localparam int unsigned NC = XC * YC;

  logic       clock;
  logic       reset;
  logic       tock_start, tock_abort, out_ready;
  logic       out_valid, out_last, busy, done;
  logic [1:0] out_x;
  logic [0:0] out_y;
  logic [7:0] frame_count;

  logic       d_start;
  logic       d_abort;
  logic       d_ready;
  logic       d_valid, d_last, d_busy, d_done;
  logic [0:0] d_x;
  logic [0:0] d_y;
  logic [7:0] d_frames;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: phase 0 idle, 1 scanning, 2 done; k is the index of the pending beat.
  int m_phase = 0;
  int m_k     = 0;
  int m_frames = 0;

  raster_scan #(
    .WIDTH   (2),
    .HEIGHT  (1),
    .X_COUNT (XC),
    .Y_COUNT (YC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tock_start  (tock_start),
    .tock_abort  (tock_abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count)
  );

  raster_scan #(
    .WIDTH   (1),
    .HEIGHT  (1),
    .X_COUNT (1),
    .Y_COUNT (1)
  ) dut1 (
    .clock       (clock),
    .reset       (reset),
    .tock_start  (d_start),
    .tock_abort  (d_abort),
    .out_valid   (d_valid),
    .out_ready   (d_ready),
    .out_x       (d_x),
    .out_y       (d_y),
    .out_last    (d_last),
    .busy        (d_busy),
    .done        (d_done),
    .frame_count (d_frames)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_phase  = 0;
      m_k      = 0;
      m_frames = 0;
    end else if (tock_abort && m_phase != 0) begin
      m_phase = 0;
      m_k     = 0;
    end else begin
      case (m_phase)
        0: if (tock_start && !tock_abort) begin
          m_phase = 1;
          m_k     = 0;
        end
        1: if (out_ready) begin
          if (m_k == NC - 1) begin
            m_phase  = 2;
            m_frames = (m_frames + 1) % 256;
            m_k      = 0;
          end else begin
            m_k = m_k + 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_valid", int'(out_valid), int'(m_phase == 1));
      check("model_busy", int'(busy), int'(m_phase == 1));
      check("model_done", int'(done), int'(m_phase == 2));
      check("model_frames", int'(frame_count), m_frames);
      if (m_phase == 1) begin
        check("model_x", int'(out_x), m_k % XC);
        check("model_y", int'(out_y), m_k / XC);
        check("model_last", int'(out_last), int'(m_k == NC - 1));
      end else begin
        check("model_last_idle", int'(out_last), 0);
      end
    end
  end

  initial begin
    logic [1:0] lit_x [6];
    logic [0:0] lit_y [6];
    lit_x = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    lit_y = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    reset = 1'b1;
    tock_start = 1'b0;
    tock_abort = 1'b0;
    out_ready  = 1'b1;
    d_start = 1'b0;
    d_abort = 1'b0;
    d_ready = 1'b1;
    repeat (2) tick();
    chk_en = 1'b1;

    @(negedge clock);
    check("rst_valid", int'(out_valid), 0);
    check("rst_x", int'(out_x), 0);
    check("rst_y", int'(out_y), 0);
    check("rst_frames", int'(frame_count), 0);
    reset = 1'b0;
    tick();

    // Constant ready: six beats, last flag on the sixth, then done.
    tock_start = 1'b1;
    tick();
    tock_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("seq_valid", int'(out_valid), 1);
      check("seq_x", int'(out_x), int'(lit_x[i]));
      check("seq_y", int'(out_y), int'(lit_y[i]));
      check("seq_last", int'(out_last), int'(i == 5));
      tick();
    end
    @(negedge clock);
    check("seq_done", int'(done), 1);
    check("seq_frames", int'(frame_count), 1);
    tick();
    @(negedge clock);
    check("seq_done_clear", int'(done), 0);

    // Backpressure held at (1,0).
    tock_start = 1'b1;
    tick();
    tock_start = 1'b0;
    tick();
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("bp_hold_x", int'(out_x), 1);
      check("bp_hold_y", int'(out_y), 0);
      check("bp_hold_valid", int'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clock);
    check("bp_resume_x", int'(out_x), 2);
    repeat (4) tick();
    @(negedge clock);
    check("bp_done", int'(done), 1);
    check("bp_frames", int'(frame_count), 2);
    tick();

    // Abort at (0,1), then restart with start held through scan and done.
    tock_start = 1'b1;
    tick();
    tock_start = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check("ab_at_x", int'(out_x), 0);
    check("ab_at_y", int'(out_y), 1);
    tock_abort = 1'b1;
    tick();
    tock_abort = 1'b0;
    @(negedge clock);
    check("ab_valid", int'(out_valid), 0);
    check("ab_busy", int'(busy), 0);
    check("ab_done", int'(done), 0);
    check("ab_frames", int'(frame_count), 2);
    tick();
    tock_start = 1'b1;
    tick();
    @(negedge clock);
    check("restart_x", int'(out_x), 0);
    check("restart_y", int'(out_y), 0);
    repeat (6) tick();
    @(negedge clock);
    check("busy_start_done", int'(done), 1);
    tick();
    tock_start = 1'b0;
    @(negedge clock);
    check("done_start_ignored", int'(out_valid), 0);
    tick();
    check("idle_frames", int'(frame_count), 3);

    // Back-to-back frames with start held: 253 more completes wrap the count.
    tock_start = 1'b1;
    repeat (253 * 8) tick();
    tock_start = 1'b0;
    tick();
    @(negedge clock);
    check("wrap_frames", int'(frame_count), 0);
    check("wrap_idle", int'(out_valid), 0);

    // Reset mid-frame at (2,0).
    tock_start = 1'b1;
    tick();
    tock_start = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    check("mid_x", int'(out_x), 2);
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("mrst_valid", int'(out_valid), 0);
    check("mrst_last", int'(out_last), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_frames", int'(frame_count), 0);
    check("mrst_x", int'(out_x), 0);
    check("mrst_y", int'(out_y), 0);
    reset = 1'b0;
    tick();

    // Degenerate 1x1 frame.
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    @(negedge clock);
    check("deg_valid", int'(d_valid), 1);
    check("deg_x", int'(d_x), 0);
    check("deg_y", int'(d_y), 0);
    check("deg_last", int'(d_last), 1);
    check("deg_busy", int'(d_busy), 1);
    tick();
    @(negedge clock);
    check("deg_done", int'(d_done), 1);
    check("deg_done_valid", int'(d_valid), 0);
    check("deg_frames", int'(d_frames), 1);
    tick();
    @(negedge clock);
    check("deg_idle", int'(d_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
